sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the team's 8x8 dual-clock FIFO.
- Data width, depth and thresholds are configurable.
- Adds an occupancy count, programmable almost-full and almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Used as the buffering stage between same-clock producer and consumer blocks.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out.
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- PTR_WIDTH, 3, log2(DEPTH); pointers are PTR_WIDTH bits wide and count is PTR_WIDTH+1 bits wide.
- AF_THRESH, 6, almost_full asserts when count >= AF_THRESH (legal range 1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (legal range 0..DEPTH-1).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  input  1  single clock; all logic updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- w_en  input  1  write request.
- r_en  input  1  read request (standard mode) or pop of the current head (FWFT mode).
- clr_err  input  1  synchronous clear of overflow and underflow.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  PTR_WIDTH+1  current occupancy, range 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset: applies on a clk edge with rst_n=0.
  - Pointers = 0, count = 0, empty = 1, almost_empty = 1.
  - full = 0, almost_full = 0, overflow = 0, underflow = 0, data_out = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data. The first write after reset lands at address 0.
- Accept rules:
  - push = w_en && !full.
  - pop = r_en && !empty.
  - Both use the registered flags from the current cycle.
- Simultaneous events:
  - w_en && r_en while neither full nor empty: both are accepted and count is unchanged.
  - When full: pop only; the write is dropped and overflow is set.
  - When empty: push only; the read is ignored and underflow is set. There is no write-through bypass.
- Count and flags:
  - count_next = count + push - pop.
  - full, empty, almost_full and almost_empty are registered and computed from count_next, so they are valid the cycle after the causing edge.
- Pointers:
  - Write pointer and read pointer are binary, PTR_WIDTH bits.
  - Each increments by 1 per push or pop and wraps from DEPTH-1 to 0 with no gap.
  - Full and empty come from count, not from pointer comparison.
- Memory:
  - Write: mem[wptr] <= data_in on push.
- Standard mode (FWFT=0):
  - On pop, data_out <= mem[rptr], visible 1 cycle after the r_en edge.
  - data_out holds its value when there is no pop.
- FWFT mode (FWFT=1):
  - data_out always shows mem[rptr] whenever empty=0.
  - The first word appears the cycle after the write edge, together with empty deasserting.
  - A pop advances to the next entry, or holds the last value if the FIFO becomes empty.
  - data_out is don't-care while empty=1. The bench checks data_out only when empty=0.
- Error flags:
  - overflow and underflow stay set until clr_err=1 or reset.
  - If clr_err is asserted in the same cycle as a new error, the error wins and the flag stays 1.
  - Error events never corrupt pointers, count or memory.

Test Plan:
- Reset, then write 0x01..0x08 on consecutive cycles (DEPTH=8), no reads -> count steps 1..8; almost_full rises after the 6th write; full=1 after the 8th; almost_empty drops after the 3rd write.
- From full, write 0xAA -> overflow=1, count stays 8; then read 8 words (FWFT=0) -> data_out 0x01..0x08, each 1 cycle after its r_en; empty=1 afterwards; a 9th read sets underflow=1; clr_err clears both flags.
- Hold count at 4 and drive w_en=r_en=1 for 20 cycles with incrementing data -> count stays 4, pointers wrap at least twice, read order exactly equals write order.
- When full, assert w_en=r_en=1 -> one word popped, write dropped, count=7, overflow=1.
- FWFT=1: write 0x5A into an empty FIFO -> next cycle empty=0 and data_out=0x5A with no r_en; assert r_en -> empty=1.
- Write 5 words, assert rst_n=0 for 1 cycle while w_en=1 -> count=0, empty=1, flags cleared; the next write/read returns the new data, not the old data.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count, almost flags, sticky errors and optional FWFT read
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic                  clr_err,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam logic [PTR_WIDTH:0] CNT_MAX = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AF      = (PTR_WIDTH+1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0] AE      = (PTR_WIDTH+1)'(AE_THRESH);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_WIDTH:0]    count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, head;
    logic                  push, pop;
    always_comb begin
        push    = w_en && !full_q;
        pop     = r_en && !empty_q;
        wptr_d  = wptr_q + PTR_WIDTH'(push);
        rptr_d  = rptr_q + PTR_WIDTH'(pop);
        count_d = count_q + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);
        full_d  = count_d == CNT_MAX;
        empty_d = count_d == '0;
        af_d    = count_d >= AF;
        ae_d    = count_d <= AE;
        ovf_d   = (w_en && full_q) || (ovf_q && !clr_err);
        unf_d   = (r_en && empty_q) || (unf_q && !clr_err);
        head    = (push && wptr_q == rptr_d) ? data_in : mem_q[rptr_d];
        dout_d  = (FWFT != 0) ? (!empty_d ? head : dout_q) : (pop ? mem_q[rptr_q] : dout_q);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            dout_q  <= dout_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= data_in;
    end
    assign data_out     = dout_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized queue-model bench driving a standard and an FWFT instance in lockstep
module tb_sync_fifo_param;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;
    logic       clk = 0;
    logic       rst_n = 0, w_en = 0, r_en = 0, clr_err = 0;
    logic [7:0] data_in = 0;
    logic [7:0] data_out, f_data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0] count, f_count;
    int         checks = 0, errors = 0;
    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_ovf, m_unf;
    always #5 clk = ~clk;
    sync_fifo_param #(.FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .clr_err(clr_err),
        .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow));
    sync_fifo_param #(.FWFT(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .clr_err(clr_err),
        .data_in(data_in), .data_out(f_data_out), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf));
    function automatic logic [9:0] exp_st();
        int n = q.size();
        return {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_unf, 4'(n)};
    endfunction
    task automatic drive(input logic w, input logic r, input logic c, input logic [7:0] d, input logic rn = 1'b1);
        logic was_full, was_empty;
        w_en = w; r_en = r; clr_err = c; data_in = d; rst_n = rn;
        @(posedge clk);
        was_full  = q.size() == DEPTH;
        was_empty = q.size() == 0;
        if (!rn) begin
            q.delete(); m_ovf = 0; m_unf = 0; m_dout = 0;
        end else begin
            m_ovf = (w && was_full) || (m_ovf && !c);
            m_unf = (r && was_empty) || (m_unf && !c);
            if (r && !was_empty) m_dout = q.pop_front();
            if (w && !was_full) q.push_back(d);
        end
        #1;
        w_en = 0; r_en = 0; clr_err = 0; rst_n = 1;
    endtask
    task automatic test_reset();
        drive(0, 0, 0, 8'h00, 0);
        drive(0, 0, 0, 8'h00, 0);
        checks++; if ({full, empty, almost_full, almost_empty, overflow, underflow, count} !== 10'b01_0100_0000) begin errors++; $display("FAIL reset_flags: got %b exp %b", {full, empty, almost_full, almost_empty, overflow, underflow, count}, 10'b01_0100_0000); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %0h exp 0", data_out); end
        checks++; if ({f_full, f_empty, f_count} !== 6'b01_0000) begin errors++; $display("FAIL reset_fwft_flags: got %b exp 010000", {f_full, f_empty, f_count}); end
    endtask
    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, 0, 0, 8'(i));
            checks++; if (count !== 4'(i)) begin errors++; $display("FAIL fill_count: got %0d exp %0d", count, i); end
            checks++; if ({full, empty, almost_full, almost_empty} !== {i == DEPTH, 1'b0, i >= AF, i <= AE}) begin errors++; $display("FAIL fill_flags[%0d]: got %b exp %b", i, {full, empty, almost_full, almost_empty}, {i == DEPTH, 1'b0, i >= AF, i <= AE}); end
        end
    endtask
    task automatic test_overflow_drain();
        drive(1, 0, 0, 8'hAA);
        checks++; if ({overflow, count} !== 5'b1_1000) begin errors++; $display("FAIL ovf_set: got ovf=%b count=%0d exp ovf=1 count=8", overflow, count); end
        for (int i = 1; i <= DEPTH; i++) begin
            checks++; if (f_data_out !== 8'(i)) begin errors++; $display("FAIL drain_fwft_head: got %0h exp %0h", f_data_out, i); end
            drive(0, 1, 0, 8'h00);
            checks++; if (data_out !== 8'(i)) begin errors++; $display("FAIL drain_dout: got %0h exp %0h", data_out, i); end
        end
        checks++; if ({empty, almost_empty, count} !== 6'b11_0000) begin errors++; $display("FAIL drain_empty: got %b exp 110000", {empty, almost_empty, count}); end
        drive(0, 1, 0, 8'h00);
        checks++; if ({overflow, underflow, data_out} !== {2'b11, 8'h08}) begin errors++; $display("FAIL unf_set: got ovf=%b unf=%b dout=%0h exp 1 1 8", overflow, underflow, data_out); end
        drive(0, 1, 1, 8'h00);
        checks++; if ({overflow, underflow} !== 2'b01) begin errors++; $display("FAIL clr_vs_error: got %b exp 01", {overflow, underflow}); end
        drive(0, 0, 1, 8'h00);
        checks++; if ({overflow, underflow, f_ovf, f_unf} !== 4'b0000) begin errors++; $display("FAIL clr_err: got %b exp 0000", {overflow, underflow, f_ovf, f_unf}); end
    endtask
    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 8'($urandom));
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 8'($urandom));
            checks++; if (count !== 4'd4) begin errors++; $display("FAIL b2b_count: got %0d exp 4", count); end
            checks++; if (data_out !== m_dout) begin errors++; $display("FAIL b2b_dout: got %0h exp %0h", data_out, m_dout); end
            checks++; if (f_data_out !== q[0]) begin errors++; $display("FAIL b2b_fwft: got %0h exp %0h", f_data_out, q[0]); end
        end
    endtask
    task automatic test_full_both();
        while (q.size() < DEPTH) drive(1, 0, 0, 8'($urandom));
        drive(1, 1, 0, 8'hEE);
        checks++; if ({overflow, full, count} !== 6'b10_0111) begin errors++; $display("FAIL full_both: got %b exp 100111", {overflow, full, count}); end
        checks++; if (data_out !== m_dout) begin errors++; $display("FAIL full_both_dout: got %0h exp %0h", data_out, m_dout); end
        drive(0, 0, 1, 8'h00);
    endtask
    task automatic test_fwft();
        drive(0, 0, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h5A);
        checks++; if ({f_empty, f_data_out} !== {1'b0, 8'h5A}) begin errors++; $display("FAIL fwft_first: got empty=%b dout=%0h exp 0 5a", f_empty, f_data_out); end
        drive(0, 1, 0, 8'h00);
        checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL fwft_pop_empty: got %b exp 1", f_empty); end
    endtask
    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 8'(8'h10 + i));
        drive(1, 0, 0, 8'h77, 0);
        checks++; if ({full, empty, almost_full, almost_empty, overflow, underflow, count} !== exp_st()) begin errors++; $display("FAIL rst_mid_flags: got %b exp %b", {full, empty, almost_full, almost_empty, overflow, underflow, count}, exp_st()); end
        drive(1, 0, 0, 8'h3C);
        checks++; if (f_data_out !== 8'h3C) begin errors++; $display("FAIL rst_mid_fwft: got %0h exp 3c", f_data_out); end
        drive(0, 1, 0, 8'h00);
        checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL rst_mid_dout: got %0h exp 3c", data_out); end
    endtask
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 5), 8'($urandom), 1'($urandom_range(0, 199) != 0));
            checks++; if ({full, empty, almost_full, almost_empty, overflow, underflow, count} !== exp_st()) begin errors++; $display("FAIL rand_flags[%0d]: got %b exp %b", i, {full, empty, almost_full, almost_empty, overflow, underflow, count}, exp_st()); end
            checks++; if ({f_full, f_empty, f_af, f_ae, f_ovf, f_unf, f_count} !== exp_st()) begin errors++; $display("FAIL rand_fwft_flags[%0d]: got %b exp %b", i, {f_full, f_empty, f_af, f_ae, f_ovf, f_unf, f_count}, exp_st()); end
            checks++; if (data_out !== m_dout) begin errors++; $display("FAIL rand_dout[%0d]: got %0h exp %0h", i, data_out, m_dout); end
            if (q.size() != 0) begin
                checks++; if (f_data_out !== q[0]) begin errors++; $display("FAIL rand_fwft_dout[%0d]: got %0h exp %0h", i, f_data_out, q[0]); end
            end
        end
    endtask
    initial begin
        m_ovf = 0; m_unf = 0; m_dout = 0;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_back_to_back();
        test_full_both();
        test_fwft();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
